// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer in front of the UART transmitter.
// Launches one byte per frame over the din/wr_en/busy handshake, with a start timeout.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2    = 4,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                  i_system_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_empty,
    output logic                  o_idle,
    input  logic                  i_clr_flags,
    output logic                  o_overflow,
    output logic                  o_stall_err,
    output logic [7:0]            o_tx_din,
    output logic                  o_tx_wr_en,
    input  logic                  i_tx_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(START_TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CW-1:0]       CNT_TC     = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0]       CNT_MAX    = CW'(START_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_tx_din;
    logic                  r_tx_wr_en;
    logic                  r_overflow;
    logic                  r_stall_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;
    logic w_stall_set;
    logic w_cnt_inc;

    assign w_full     = (r_level == LEVEL_FULL);
    assign w_empty    = (r_level == '0);
    // Refusal depends only on registered fullness, so a same-cycle pop never frees a slot.
    assign w_push     = i_wr_valid && !w_full;
    assign w_ovf_set  = i_wr_valid && w_full;

    assign o_wr_ready  = !w_full;
    assign o_level     = r_level;
    assign o_empty     = w_empty;
    assign o_idle      = w_empty && (r_state == S_IDLE);
    assign o_overflow  = r_overflow;
    assign o_stall_err = r_stall_err;
    assign o_tx_din    = r_tx_din;
    assign o_tx_wr_en  = r_tx_wr_en;

    always_ff @(posedge i_system_clk) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (!w_empty && !i_tx_busy) w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (i_tx_busy)             w_state_nxt = S_WAIT_DONE;
                else if (r_cnt >= CNT_TC)  w_state_nxt = S_IDLE;
            end
            S_WAIT_DONE: if (!i_tx_busy) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_stall_set = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE:      w_pop = !w_empty && !i_tx_busy;
            S_WAIT_BUSY: begin
                w_cnt_inc   = !i_tx_busy;
                w_stall_set = !i_tx_busy && (r_cnt >= CNT_TC);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_system_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_system_clk) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Counter saturates at START_TIMEOUT; the compare fires one count early so the flag lands on it.
    always_ff @(posedge i_system_clk) begin
        if (!i_reset)                          r_cnt <= '0;
        else if (w_pop)                        r_cnt <= '0;
        else if (w_cnt_inc && r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
    end

    always_ff @(posedge i_system_clk) begin
        if (!i_reset) begin
            r_tx_din    <= 8'h00;
            r_tx_wr_en  <= 1'b0;
            r_overflow  <= 1'b0;
            r_stall_err <= 1'b0;
        end else begin
            r_tx_wr_en <= w_pop;
            if (w_pop) r_tx_din <= r_mem[r_rd_ptr];
            if (w_ovf_set)        r_overflow <= 1'b1;
            else if (i_clr_flags) r_overflow <= 1'b0;
            if (w_stall_set)      r_stall_err <= 1'b1;
            else if (i_clr_flags) r_stall_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter busy model.
// START_TIMEOUT is set to 8 so the stall case is short.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] level;
    logic       empty;
    logic       idle;
    logic       clr_flags;
    logic       overflow;
    logic       stall_err;
    logic [7:0] tx_din;
    logic       tx_wr_en;
    logic       tx_busy;

    uart_tx_feeder #(.DEPTH_LOG2(4), .START_TIMEOUT(8)) dut (
        .i_system_clk (clk),
        .i_reset      (rst_n),
        .i_wr_data    (wr_data),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .o_level      (level),
        .o_empty      (empty),
        .o_idle       (idle),
        .i_clr_flags  (clr_flags),
        .o_overflow   (overflow),
        .o_stall_err  (stall_err),
        .o_tx_din     (tx_din),
        .o_tx_wr_en   (tx_wr_en),
        .i_tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = -100;
    int n_launch = 0;
    int busy_len = 10;
    int busy_left = 0;
    bit pend_start = 0;
    bit model_en = 1;
    bit gap_chk = 0;
    logic [7:0] got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, update the transmitter model, log launches.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (model_en) begin
            if (pend_start) begin
                tx_busy = 1'b1;
                busy_left = busy_len;
                pend_start = 0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy = 1'b0;
                    fall_cyc = cyc;
                end
            end
        end
        if (tx_wr_en) begin
            got.push_back(tx_din);
            n_launch++;
            if (model_en) pend_start = 1;
            if (gap_chk) chk("launch_gap_ge2", 32'(cyc - fall_cyc >= 2), 1);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(idle && !tx_busy && !pend_start && busy_left == 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    initial begin
        int peak;
        int n;
        int n0;
        rst_n = 1'b0;
        wr_data = 8'h00;
        wr_valid = 1'b0;
        clr_flags = 1'b0;
        tx_busy = 1'b0;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_tx_din", tx_din, 8'h00);
        chk("rst_tx_wr_en", tx_wr_en, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_idle", idle, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_stall_err", stall_err, 0);

        // Single byte: pop decision next cycle, launch the cycle after
        for (int i = 0; i < 6; i++) tick();
        busy_len = 10;
        write_byte(8'hA5);
        chk("single_level_n1", level, 1);
        chk("single_empty_n1", empty, 0);
        chk("single_wr_en_n1", tx_wr_en, 0);
        tick();
        chk("single_wr_en_n2", tx_wr_en, 1);
        chk("single_din_n2", tx_din, 8'hA5);
        chk("single_level_n2", level, 0);
        tick();
        chk("single_wr_en_n3", tx_wr_en, 0);
        chk("single_din_hold", tx_din, 8'hA5);
        n = 0;
        while (!idle && n < 100) begin
            tick();
            n++;
        end
        chk("single_idle_seen", 32'(n < 100), 1);
        chk("single_idle_after_fall", 32'(cyc - fall_cyc), 1);
        chk("single_got", got[0], 8'hA5);

        // Burst of 16 with long frames: ordering, peak level, launch spacing
        got.delete();
        busy_len = 50;
        gap_chk = 1;
        peak = 0;
        for (int i = 1; i <= 16; i++) begin
            write_byte(8'(i));
            if (int'(level) > peak) peak = int'(level);
        end
        chk("burst_peak_level", peak, 15);
        chk("burst_wr_ready", wr_ready, 1);
        chk("burst_no_overflow", overflow, 0);
        wait_idle("burst_drain", 1500);
        gap_chk = 0;
        chk("burst_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("burst_order", got[i], 8'(i + 1));

        // Overflow with busy held high
        got.delete();
        model_en = 0;
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
        chk("ovf_level_full", level, 16);
        chk("ovf_wr_ready_full", wr_ready, 0);
        chk("ovf_flag_before", overflow, 0);
        write_byte(8'hEE);
        chk("ovf_flag_set", overflow, 1);
        chk("ovf_level_unchanged", level, 16);
        clr_flags = 1'b1;
        write_byte(8'hEE);
        chk("ovf_set_wins_clr", overflow, 1);
        tick();
        clr_flags = 1'b0;
        chk("ovf_cleared", overflow, 0);
        chk("ovf_no_launch_while_busy", got.size(), 0);
        tx_busy = 1'b0;
        busy_left = 0;
        pend_start = 0;
        busy_len = 5;
        model_en = 1;
        wait_idle("ovf_drain", 600);
        chk("ovf_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("ovf_order", got[i], 8'h80 + 8'(i));

        // Stall timeout: transmitter never goes busy
        got.delete();
        model_en = 0;
        tx_busy = 1'b0;
        write_byte(8'h33);
        write_byte(8'h44);
        chk("stall_launch", tx_wr_en, 1);
        chk("stall_din", tx_din, 8'h33);
        for (int i = 0; i < 7; i++) tick();
        chk("stall_not_yet", stall_err, 0);
        tick();
        chk("stall_set", stall_err, 1);
        chk("stall_wr_en_low", tx_wr_en, 0);
        model_en = 1;
        tick();
        chk("stall_next_launch", tx_wr_en, 1);
        chk("stall_next_din", tx_din, 8'h44);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("stall_cleared", stall_err, 0);
        wait_idle("stall_drain", 200);
        chk("stall_count", got.size(), 2);

        // Pointer wrap: 40 bytes paced by wr_ready
        got.delete();
        busy_len = 2;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (!wr_ready && n < 50) begin
                tick();
                n++;
            end
            chk("wrap_ready_wait", 32'(n < 50), 1);
            write_byte(8'(i));
        end
        wait_idle("wrap_drain", 800);
        chk("wrap_count", got.size(), 40);
        for (int i = 0; i < 40 && i < got.size(); i++) chk("wrap_order", got[i], 8'(i));
        chk("wrap_level_zero", level, 0);
        chk("wrap_no_overflow", overflow, 0);

        // Reset while in WAIT_DONE with 5 bytes queued
        got.delete();
        busy_len = 30;
        for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i));
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_busy", tx_busy, 1);
        chk("midrst_level_before", level, 5);
        rst_n = 1'b0;
        model_en = 0;
        tx_busy = 1'b0;
        busy_left = 0;
        pend_start = 0;
        tick();
        rst_n = 1'b1;
        chk("midrst_level", level, 0);
        chk("midrst_wr_en", tx_wr_en, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_empty", empty, 1);
        n0 = n_launch;
        model_en = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("midrst_no_launch", n_launch - n0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter. Accepts bytes from the host-side logic into a FIFO at system-clock rate, then hands them one at a time to the transmitter via its `din`/`wr_en`/`tx_busy` handshake. It launches the next byte only after the previous frame has fully completed, so the host never has to pace writes against the bit rate.

## Interface
- `DEPTH_LOG2`, default 4. FIFO depth is 2^DEPTH_LOG2 entries (16).
- `START_TIMEOUT`, default 1023. Maximum system_clk cycles to wait for `tx_busy` to rise after a launch.
- `system_clk`, input, 1. Single clock for all logic.
- `reset`, input, 1. Synchronous, active-low.
- `wr_data`, input, 8. Byte to enqueue.
- `wr_valid`, input, 1. Enqueue request.
- `wr_ready`, output, 1. High when the FIFO is not full.
- `level`, output, DEPTH_LOG2+1. Current FIFO occupancy, 0..2^DEPTH_LOG2.
- `empty`, output, 1. Asserted when `level` is 0.
- `idle`, output, 1. Asserted when `empty` is high and the state is IDLE.
- `clr_flags`, input, 1. Clears the sticky flags.
- `overflow`, output, 1. Sticky flag: a write was attempted while full.
- `stall_err`, output, 1. Sticky flag: the transmitter never went busy.
- `tx_din`, output, 8. Byte presented to the transmitter.
- `tx_wr_en`, output, 1. One-cycle launch pulse to the transmitter.
- `tx_busy`, input, 1. Transmitter busy status.

## Operation
- FIFO
  - Circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth; `level` is a separate counter.
  - A write is accepted when `wr_valid & wr_ready`.
  - A write is refused when full, even if a pop happens in the same cycle.
  - Refused write: sets `overflow`; data is dropped; FIFO is unchanged.
  - Write and pop in the same cycle: `level` is unchanged and both pointers advance.
  - No bypass: a byte written into an empty FIFO is launched no earlier than the following cycle.
- State machine: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: when `!empty & !tx_busy`, pop the head into `tx_din`, assert `tx_wr_en` (registered, next cycle), clear the timeout counter, and go to WAIT_BUSY. If `tx_busy` is already high, stay in IDLE.
  - WAIT_BUSY: `tx_wr_en` is high for the first cycle only. When `tx_busy` = 1, go to WAIT_DONE. Otherwise increment the counter; when the counter reaches START_TIMEOUT, set `stall_err` and return to IDLE. The byte is lost and is not re-queued.
  - WAIT_DONE: when `tx_busy` = 0, go to IDLE.
- `tx_din` holds its value from launch until the next launch. The transmitter samples `din` on its own bit-rate edge, so `tx_din` must not change while busy.
- `clr_flags` clears `overflow` and `stall_err`. If a new error event occurs in the same cycle, the set wins.
- Timeout counter width is clog2(START_TIMEOUT+1); it saturates and never wraps.

## Timing
- Reset values:
  - `tx_din` = 0x00, `tx_wr_en` = 0.
  - `wr_ready` = 1, `level` = 0, `empty` = 1, `idle` = 1.
  - `overflow` = 0, `stall_err` = 0.
  - State = IDLE; pointers and counter = 0.
- Write accepted at the edge ending cycle N: `level` and `empty` update in N+1.
- Launch latency, from a write at cycle N (FIFO empty, IDLE, `tx_busy` low):
  - Pop decision in N+1.
  - `tx_din` valid and `tx_wr_en` = 1 in N+2, for exactly one cycle.
  - `level` decrements in N+2.
- Back-to-back bytes: the next pop happens the cycle after `tx_busy` is seen low in WAIT_DONE plus one IDLE cycle. Minimum gap from `tx_busy` falling to the next `tx_wr_en` pulse is 2 cycles.
- `wr_ready`, `empty`, `level` and `idle` are derived combinationally from registered `level` and state; no input-to-output combinational paths.
- Reset mid-operation:
  - Buffered bytes are discarded, flags are cleared, and the state returns to IDLE immediately.
  - A pending `tx_wr_en` is cancelled.
  - The transmitter shares `reset` and aborts on its own.
- `tx_busy` stuck high at reset release: IDLE holds off launching until it falls.

## Test plan
- Single byte: reset, write 0xA5 at cycle 10 with `tx_busy` low -> `tx_wr_en` pulses for one cycle at cycle 12 with `tx_din` = 0xA5. Model `tx_busy` high 3..40 cycles later -> `idle` = 1 after busy falls plus 1 cycle.
- Burst and ordering: write 0x01..0x10 on consecutive cycles with a transmitter model busy for 50 cycles per byte -> bytes emerge in order. `level` peaks at 15 or 16 and `wr_ready` = 0 only at 16. Each new `tx_wr_en` comes ≥2 cycles after `tx_busy` falls.
- Overflow: fill 16 entries while `tx_busy` is held high, then write 0xEE -> `overflow` = 1, `level` = 16, and 0xEE is never transmitted. Pulse `clr_flags` -> `overflow` = 0.
- Stall timeout with START_TIMEOUT = 8: write 0x33 and never raise `tx_busy` -> `stall_err` = 1 exactly 8 cycles after the `tx_wr_en` cycle. State returns to IDLE and the next queued byte 0x44 launches normally.
- Pointer wrap: push and pop 40 bytes (0x00..0x27) through the FIFO -> all 40 delivered in order and `level` returns to 0.
- Reset mid-frame: assert `reset` low for 1 cycle while in WAIT_DONE with 5 bytes queued -> next cycle `level` = 0, `tx_wr_en` = 0, `idle` = 1. No further launches occur without new writes.
